// File: rtl/eff_sel_ctrl_pkg.sv
// Shared types and constants for the effect-select path: gain word and effect-select word.
// The fade sequence in eff_sel_ctrl is built only when EFF_SEL_CTRL_FADE_EN is defined.
package eff_sel_ctrl_pkg;

  localparam int unsigned GAIN_W   = 8;
  localparam int unsigned GAIN_MAX = (1 << GAIN_W) - 1;
  localparam int unsigned SEL_W    = 16;

  typedef logic [GAIN_W-1:0] gain_t;
  typedef logic [SEL_W-1:0]  eff_sel_t;

endpackage

// File: rtl/eff_sel_ctrl_sw_debounce.sv
// Multi-bit switch debouncer: the output follows the input only after the input has held
// the same value for DEB_CYCLES consecutive comparisons.
module sw_debounce #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEB_CYCLES = 245760
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] sig_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] r_deb;
  logic [CNT_W-1:0] r_cnt;

  // Counter saturates at CNT_LAST so a long-held input keeps refreshing the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw <= '0;
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      r_raw <= sig_i;
      if (sig_i != r_raw) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_raw;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sig_o = r_deb;

endmodule

// File: rtl/eff_sel_ctrl.sv
// Click-free effect-selection controller: debounces the switch bank and swaps the effect
// select under a gain fade. Fade is built only when EFF_SEL_CTRL_FADE_EN is defined.
module eff_sel_ctrl
  import eff_sel_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 245760,
  parameter int unsigned GAIN_W     = eff_sel_ctrl_pkg::GAIN_W,
  parameter int unsigned FADE_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  eff_sel_t          sw_i,
  input  logic              vld_i,
  output eff_sel_t          sel_o,
  output logic [GAIN_W-1:0] gain_o,
  output logic              busy_o
);

  localparam logic [GAIN_W-1:0] GAIN_UNITY = '1;

  if (FADE_STEP < 1 || FADE_STEP > ((1 << GAIN_W) - 1)) begin : g_bad_step
    $error("FADE_STEP must lie in 1..2**GAIN_W-1");
  end

  typedef enum logic [1:0] {StIdle, StFadeOut, StSwap, StFadeIn} state_e;

  state_e   r_state, w_state_nxt;
  eff_sel_t r_sel, w_sel_nxt;
  eff_sel_t r_pend, w_pend_nxt;
  eff_sel_t w_deb;

  sw_debounce #(
    .WIDTH      (SEL_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .clk   (clk),
    .rst   (rst),
    .sig_i (sw_i),
    .sig_o (w_deb)
  );

`ifdef EFF_SEL_CTRL_FADE_EN
  localparam logic [GAIN_W:0] STEP_EXT = FADE_STEP[GAIN_W:0];

  logic [GAIN_W-1:0] r_gain, w_gain_nxt, w_gain_dn, w_gain_up;
  logic [GAIN_W:0]   w_gain_ext, w_diff, w_sum;

  // One extra bit of headroom so the clamps see underflow/overflow instead of a wrap.
  always_comb begin
    w_gain_ext = {1'b0, r_gain};
    w_diff     = w_gain_ext - STEP_EXT;
    w_sum      = w_gain_ext + STEP_EXT;
    w_gain_dn  = (w_gain_ext < STEP_EXT) ? '0 : w_diff[GAIN_W-1:0];
    w_gain_up  = (w_sum > {1'b0, GAIN_UNITY}) ? GAIN_UNITY : w_sum[GAIN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain <= GAIN_UNITY;
    end else begin
      r_gain <= w_gain_nxt;
    end
  end

  assign gain_o = r_gain;
`else
  logic w_unused_vld;
  assign w_unused_vld = vld_i;
  assign gain_o       = GAIN_UNITY;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_pend_nxt  = r_pend;
`ifdef EFF_SEL_CTRL_FADE_EN
    w_gain_nxt  = r_gain;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_deb != r_sel) begin
          w_pend_nxt = w_deb;
`ifdef EFF_SEL_CTRL_FADE_EN
          w_state_nxt = StFadeOut;
`else
          w_state_nxt = StSwap;
`endif
        end
      end
`ifdef EFF_SEL_CTRL_FADE_EN
      StFadeOut: begin
        // Latest debounced selection wins until the swap actually happens.
        w_pend_nxt = w_deb;
        if (r_gain == '0) begin
          w_state_nxt = StSwap;
        end else if (vld_i) begin
          w_gain_nxt = w_gain_dn;
        end
      end
      StFadeIn: begin
        // A new selection reverses the fade from wherever the gain currently sits.
        if (w_deb != r_sel) begin
          w_pend_nxt  = w_deb;
          w_state_nxt = StFadeOut;
        end else if (r_gain == GAIN_UNITY) begin
          w_state_nxt = StIdle;
        end else if (vld_i) begin
          w_gain_nxt = w_gain_up;
        end
      end
`endif
      StSwap: begin
        w_sel_nxt = r_pend;
`ifdef EFF_SEL_CTRL_FADE_EN
        w_state_nxt = StFadeIn;
`else
        w_state_nxt = StIdle;
`endif
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_sel   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign sel_o  = r_sel;
  assign busy_o = (r_state != StIdle);

endmodule

// File: tb/tb_eff_sel_ctrl.sv
// Self-checking bench for eff_sel_ctrl: directed cases plus randomized switch/strobe traffic,
// compared every cycle against a sliding-window debounce and phase-level fade model.
module tb_eff_sel_ctrl;

  localparam int DEB  = 8;
  localparam int GW   = 4;
  localparam int STEP = 4;
  localparam int GMAX = 15;

  localparam int P_IDLE = 0;
  localparam int P_FO   = 1;
  localparam int P_SWAP = 2;
  localparam int P_FI   = 3;

`ifdef EFF_SEL_CTRL_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [15:0]   sw  = '0;
  logic [15:0]   sel;
  logic [GW-1:0] gain;
  logic          busy;

  eff_sel_ctrl #(
    .DEB_CYCLES (DEB),
    .GAIN_W     (GW),
    .FADE_STEP  (STEP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_i   (sw),
    .vld_i  (vld),
    .sel_o  (sel),
    .gain_o (gain),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int vld_mode = 0;
  int cyc_n    = 0;
  int n;

  logic [15:0] m_hist[$];
  logic [15:0] m_deb, m_sel, m_pend;
  int          m_gain, m_ph;

  int glog[$];
  int last_gain;
  bit saw5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Debounced value = sw once the last DEB+1 samples agree (reset counts as a sample of 0).
  task automatic model_step();
    logic [15:0] deb_old;
    bit          same;
    int          g;
    if (rst) begin
      m_hist.delete();
      m_hist.push_back(16'h0);
      m_deb  = '0;
      m_sel  = '0;
      m_pend = '0;
      m_gain = GMAX;
      m_ph   = P_IDLE;
    end else begin
      deb_old = m_deb;
      m_hist.push_back(sw);
      if (m_hist.size() > DEB + 1) void'(m_hist.pop_front());
      if (m_hist.size() == DEB + 1) begin
        same = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] !== sw) same = 1'b0;
        if (same) m_deb = sw;
      end
      case (m_ph)
        P_IDLE: if (deb_old != m_sel) begin
          m_pend = deb_old;
          m_ph   = FADE_EN ? P_FO : P_SWAP;
        end
        P_FO: begin
          m_pend = deb_old;
          if (m_gain == 0) m_ph = P_SWAP;
          else if (vld) begin
            g = m_gain - STEP;
            m_gain = (g < 0) ? 0 : g;
          end
        end
        P_SWAP: begin
          m_sel = m_pend;
          m_ph  = FADE_EN ? P_FI : P_IDLE;
        end
        default: begin
          if (deb_old != m_sel) begin
            m_pend = deb_old;
            m_ph   = P_FO;
          end else if (m_gain == GMAX) m_ph = P_IDLE;
          else if (vld) begin
            g = m_gain + STEP;
            m_gain = (g > GMAX) ? GMAX : g;
          end
        end
      endcase
    end
  endtask

  task automatic cyc();
    case (vld_mode)
      0:       vld = ((cyc_n % 4) == 3);
      1:       vld = ($urandom_range(0, 2) == 0);
      default: vld = 1'b0;
    endcase
    cyc_n++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("sel", sel, m_sel);
    chk("gain", gain, m_gain);
    chk("busy", busy, m_ph != P_IDLE);
    if (int'(gain) != last_gain) begin
      glog.push_back(int'(gain));
      last_gain = int'(gain);
    end
    if (sel == 16'h0005) saw5 = 1'b1;
  endtask

  initial begin
    int exp3[8];
    int exp4[6];
    exp3 = '{11, 7, 3, 0, 4, 8, 12, 15};
    exp4 = '{4, 0, 4, 8, 12, 15};
    last_gain = GMAX;

    // Reset and idle
    rst = 1'b1;
    sw  = '0;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_sel", sel, 16'h0);
    chk("rst_gain", gain, GMAX);
    chk("rst_busy", busy, 1'b0);
    repeat (100) cyc();

    // Bouncing switch never settles long enough
    for (int i = 0; i < 30; i++) begin
      sw = (((i / 3) % 2) == 0) ? 16'h0001 : 16'h0000;
      cyc();
    end
    sw = '0;
    repeat (20) cyc();
    chk("bounce_busy", busy, 1'b0);
    chk("bounce_sel", sel, 16'h0);

    // Basic swap
    glog.delete();
    last_gain = int'(gain);
    sw = 16'h0005;
    n  = 0;
    while (!busy && n < 20) begin cyc(); n++; end
    chk("c3_busy_lat", n, 10);
`ifdef EFF_SEL_CTRL_FADE_EN
    n = 0;
    while (busy && n < 300) begin cyc(); n++; end
    chk("c3_done", busy, 1'b0);
    chk("c3_sel", sel, 16'h0005);
    chk("c3_log_len", glog.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("c3_log%0d", i), glog[i], exp3[i]);

    // Change while fading in at gain 8
    sw = 16'h000A;
    n  = 0;
    while (!(sel == 16'h000A && gain == 4'd8 && busy) && n < 300) begin cyc(); n++; end
    chk("c4_reach", n < 300, 1'b1);
    vld_mode = 2;
    glog.delete();
    last_gain = int'(gain);
    sw = 16'h0003;
    repeat (10) cyc();
    vld_mode = 0;
    n = 0;
    while (busy && n < 300) begin cyc(); n++; end
    chk("c4_sel", sel, 16'h0003);
    chk("c4_gain", gain, GMAX);
    chk("c4_log_len", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("c4_log%0d", i), glog[i], exp4[i]);

    // Change while fading out: one swap, straight to the newest value
    sw = 16'h0005;
    n  = 0;
    while (!busy && n < 20) begin cyc(); n++; end
    saw5 = 1'b0;
    sw = 16'h0006;
    n  = 0;
    while (busy && n < 300) begin cyc(); n++; end
    chk("c5_no5", saw5, 1'b0);
    chk("c5_sel", sel, 16'h0006);

    // Reset mid-fade
    sw = 16'h0009;
    n  = 0;
    while (gain != 4'd7 && n < 200) begin cyc(); n++; end
    chk("c6_reach", n < 200, 1'b1);
    rst = 1'b1;
    cyc();
    chk("c6_sel", sel, 16'h0);
    chk("c6_gain", gain, GMAX);
    chk("c6_busy", busy, 1'b0);
    rst = 1'b0;
`else
    cyc();
    chk("c3_sel_lat", sel, 16'h0005);
    chk("c3_busy_one", busy, 1'b0);
    chk("c3_gain", gain, GMAX);
    chk("c3_log_len", glog.size(), 0);
    sw = 16'h000A;
    n  = 0;
    while (!busy && n < 20) begin cyc(); n++; end
    chk("c3b_busy_lat", n, 10);
    chk("c3b_sel_hold", sel, 16'h0005);
    cyc();
    chk("c3b_sel", sel, 16'h000A);
    chk("c3b_busy_one", busy, 1'b0);
`endif
    sw = '0;
    repeat (40) cyc();

    // Randomized traffic
    vld_mode = 1;
    n = 0;
    while (n < 1500) begin
      case ($urandom_range(0, 5))
        0:       sw = 16'h0000;
        1:       sw = 16'h0001;
        2:       sw = 16'h0005;
        3:       sw = 16'h0006;
        4:       sw = 16'hA5A5;
        default: sw = 16'($urandom);
      endcase
      repeat ($urandom_range(1, 40)) begin
        rst = ($urandom_range(0, 299) == 0);
        cyc();
        n++;
      end
    end
    rst = 1'b0;
    repeat (5) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
